stack_alu_sequencer: RTL and testbench
======================================

// Module: stack_alu_sequencer
// PURPOSE
//  Command sequencer between the user inputs and the ALU + stack/queue memory datapath.
//  Takes single-cycle pre-debounced commands (push switches, pop, execute op) and sequences the memory strobes.
//  Execute runs pop operand, pop operand, ALU compute, push result. Tracks occupancy and flags illegal commands.
// PARAMETERS
//  WIDTH  32  datapath / memory word width
//  DEPTH  16  memory entries; must equal the connected memory depth
//  SW_W   16  switch width; zero-extended to WIDTH on push
//  OP_W   4   ALU opcode width
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  sel        in   1          0 = stack (LIFO), 1 = queue (FIFO); same signal drives memory mode
//  cmd_push   in   1          1-cycle pulse: push zero-extended switches
//  cmd_pop    in   1          1-cycle pulse: discard top/head entry
//  cmd_exec   in   1          1-cycle pulse: execute cmd_op on two entries
//  cmd_op     in   OP_W       ALU opcode, sampled with cmd_exec
//  switches   in   SW_W       user data
//  mem_dout   in   WIDTH      memory top/head, show-ahead; new value valid the cycle after a pop edge
//  mem_empty  in   1          memory empty flag
//  mem_full   in   1          memory full flag
//  alu_y      in   WIDTH      combinational ALU result
//  mem_din    out  WIDTH      memory write data
//  mem_push   out  1          memory push strobe, 1 cycle
//  mem_pop    out  1          memory pop strobe, 1 cycle
//  alu_a      out  WIDTH      ALU operand A (registered)
//  alu_b      out  WIDTH      ALU operand B (registered)
//  alu_op     out  OP_W       ALU opcode (registered)
//  busy       out  1          high in every state except IDLE
//  err        out  1          sticky illegal-command flag
//  count      out  clog2(DEPTH+1)  occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async): state IDLE; every output and internal register is 0.
//  Moore FSM. mem_push and mem_pop decode from state only; both are never high together.
//  States: IDLE, PUSH_SW, POP_USR, POP1, POP2, CALC, PUSH_R.
//  IDLE acceptance: priority exec > pop > push; lower-priority simultaneous pulses are dropped.
//   exec: legal if count>=2 and !mem_empty. Latches cmd_op into alu_op and sel into sel_q. Goes to POP1.
//   pop:  legal if count>=1 and !mem_empty. Goes to POP_USR.
//   push: legal if count<DEPTH and !mem_full. Latches {0,switches} into mem_din. Goes to PUSH_SW.
//   illegal: err<=1, stays IDLE, no strobe, count unchanged.
//   legal acceptance: err<=0.
//  PUSH_SW: mem_push=1, count+1, then IDLE.  POP_USR: mem_pop=1, count-1, then IDLE.
//  POP1: mem_pop=1, count-1. Capture mem_dout: into alu_b if sel_q=0, into alu_a if sel_q=1.
//  POP2: mem_pop=1, count-1. Capture mem_dout into the other operand.
//   Stack gives A = older entry, B = newer. Queue gives A = first dequeued.
//  CALC: operands stable; capture alu_y into mem_din.
//  PUSH_R: mem_push=1, count+1, then IDLE.
//  Exec latency: accept edge at cycle 0; POP1=1, POP2=2, CALC=3, PUSH_R=4; busy low in cycle 5. Net count -1.
//  Commands arriving while busy: dropped, err unchanged.
//  ALU overflow: ignored; result is truncated to WIDTH.
//  Mid-operation changes to sel or cmd_op: no effect; the latched values are used.
//  rst mid-exec: immediate IDLE, count 0. The memory shares rst, so no partial entries remain.
//  count never wraps: the legality checks guarantee 0..DEPTH.
// STRUCTURE
//  Shared package: state enum, ST_* encodings, CNT_W = $clog2(DEPTH+1).
//  Sub-module sq_occupancy_counter: inc/dec/clear inputs, saturating at 0 and DEPTH.
//   It exposes ge2, nonzero and lt_full compares. The FSM and operand registers live in this module.
// TESTING
//  1. Reset, then push sw=5, then push sw=3 -> two 1-cycle mem_push with mem_din 5, 3; count=2, err=0.
//  2. Stack, ADD opcode exec on [5,3] -> pops in cycles 1-2; alu_a=5, alu_b=3; push 8 in cycle 4; count=1; busy 4 cycles.
//  3. Queue, SUB exec on [9,4] with 9 first -> alu_a=9, alu_b=4; result pushed; count drops by 1.
//  4. count=1, exec -> no strobes, err=1. Next legal push -> err=0.
//  5. Fill to DEPTH, push again -> err=1, no mem_push. Pop at count=0 -> err=1.
//  6. Pulses during busy are dropped; simultaneous exec+pop+push picks exec. rst in POP2 -> all outputs 0 on the async edge.

Source files
------------

// File: rtl/stack_alu_sequencer_pkg.sv
// rtl/stack_alu_sequencer_pkg.sv - shared types and defaults for the stack/queue ALU sequencer
package stack_alu_sequencer_pkg;

  localparam int WIDTH_D = 32;
  localparam int DEPTH_D = 16;
  localparam int SW_W_D  = 16;
  localparam int OP_W_D  = 4;
  localparam int CNT_W   = $clog2(DEPTH_D + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_SW = 3'd1,
    ST_POP_USR = 3'd2,
    ST_POP1    = 3'd3,
    ST_POP2    = 3'd4,
    ST_CALC    = 3'd5,
    ST_PUSH_R  = 3'd6
  } state_t;

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// rtl/stack_alu_sequencer_if.sv - command, memory and ALU signal bundle for the sequencer
interface stack_alu_sequencer_if
  import stack_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int SW_W  = SW_W_D,
  parameter int OP_W  = OP_W_D
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             sel;
  logic             cmd_push;
  logic             cmd_pop;
  logic             cmd_exec;
  logic [OP_W-1:0]  cmd_op;
  logic [SW_W-1:0]  switches;
  logic [WIDTH-1:0] mem_dout;
  logic             mem_empty;
  logic             mem_full;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] mem_din;
  logic             mem_push;
  logic             mem_pop;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_op;
  logic             busy;
  logic             err;
  logic [CW-1:0]    count;

  modport master (
    input  sel, cmd_push, cmd_pop, cmd_exec, cmd_op, switches,
    input  mem_dout, mem_empty, mem_full, alu_y,
    output mem_din, mem_push, mem_pop, alu_a, alu_b, alu_op, busy, err, count
  );

  modport slave (
    output sel, cmd_push, cmd_pop, cmd_exec, cmd_op, switches,
    output mem_dout, mem_empty, mem_full, alu_y,
    input  mem_din, mem_push, mem_pop, alu_a, alu_b, alu_op, busy, err, count
  );

endinterface

// File: rtl/stack_alu_sequencer_occupancy_counter.sv
// rtl/stack_alu_sequencer_occupancy_counter.sv - saturating occupancy counter with legality compares
module sq_occupancy_counter
  import stack_alu_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          ge2,
  output logic          nonzero,
  output logic          lt_full
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !dec && count != FULL) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign ge2     = (count >= CW'(2));
  assign nonzero = (count != '0);
  assign lt_full = (count < FULL);

endmodule

// File: rtl/stack_alu_sequencer.sv
// rtl/stack_alu_sequencer.sv - sequences push/pop/execute commands onto the ALU and stack/queue memory
module stack_alu_sequencer
  import stack_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int SW_W  = SW_W_D,
  parameter int OP_W  = OP_W_D
) (
  input logic                  clk,
  input logic                  rst,
  stack_alu_sequencer_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  state_t        state, nxt;
  logic          sel_q;
  logic [CW-1:0] cnt;
  logic          ge2, nonzero, lt_full;
  logic          acc_exec, acc_pop, acc_push, reject;
  logic          inc, dec;

  assign inc = (state == ST_PUSH_SW) || (state == ST_PUSH_R);
  assign dec = (state == ST_POP_USR) || (state == ST_POP1) || (state == ST_POP2);

  sq_occupancy_counter #(.DEPTH(DEPTH), .CW(CW)) u_occ (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .dec     (dec),
    .clear   (1'b0),
    .count   (cnt),
    .ge2     (ge2),
    .nonzero (nonzero),
    .lt_full (lt_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Only IDLE looks at commands, so anything arriving while busy is dropped silently.
  always_comb begin
    nxt      = state;
    acc_exec = 1'b0;
    acc_pop  = 1'b0;
    acc_push = 1'b0;
    reject   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_exec) begin
          if (ge2 && !bus.mem_empty) begin acc_exec = 1'b1; nxt = ST_POP1; end
          else reject = 1'b1;
        end else if (bus.cmd_pop) begin
          if (nonzero && !bus.mem_empty) begin acc_pop = 1'b1; nxt = ST_POP_USR; end
          else reject = 1'b1;
        end else if (bus.cmd_push) begin
          if (lt_full && !bus.mem_full) begin acc_push = 1'b1; nxt = ST_PUSH_SW; end
          else reject = 1'b1;
        end
      end
      ST_PUSH_SW: nxt = ST_IDLE;
      ST_POP_USR: nxt = ST_IDLE;
      ST_POP1:    nxt = ST_POP2;
      ST_POP2:    nxt = ST_CALC;
      ST_CALC:    nxt = ST_PUSH_R;
      ST_PUSH_R:  nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  assign bus.mem_push = (state == ST_PUSH_SW) || (state == ST_PUSH_R);
  assign bus.mem_pop  = dec;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.count    = cnt;

  // A stack yields the newer operand first (B); a queue yields the first-enqueued first (A).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= 1'b0;
      bus.err     <= 1'b0;
      bus.mem_din <= '0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_op  <= '0;
    end else begin
      if (acc_exec || acc_pop || acc_push) bus.err <= 1'b0;
      else if (reject)                     bus.err <= 1'b1;
      if (acc_exec) begin
        bus.alu_op <= bus.cmd_op;
        sel_q      <= bus.sel;
      end
      if (acc_push) bus.mem_din <= {{(WIDTH-SW_W){1'b0}}, bus.switches};
      if (state == ST_POP1) begin
        if (sel_q) bus.alu_a <= bus.mem_dout;
        else       bus.alu_b <= bus.mem_dout;
      end
      if (state == ST_POP2) begin
        if (sel_q) bus.alu_b <= bus.mem_dout;
        else       bus.alu_a <= bus.mem_dout;
      end
      if (state == ST_CALC) bus.mem_din <= bus.alu_y;
    end
  end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb/tb_stack_alu_sequencer.sv - scoreboard bench for stack_alu_sequencer with stack/queue and ALU models
module tb_stack_alu_sequencer;
  import stack_alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_alu_sequencer_if #(.WIDTH(32), .DEPTH(16), .SW_W(16), .OP_W(4)) bus ();

  stack_alu_sequencer #(.WIDTH(32), .DEPTH(16), .SW_W(16), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Memory model: m[lo..hi-1] holds entries; stack uses the hi end, queue pops from lo.
  logic [31:0] m [0:63];
  logic [5:0]  lo, hi;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lo <= '0;
      hi <= '0;
    end else begin
      if (bus.mem_push) begin
        m[hi] <= bus.mem_din;
        hi    <= hi + 6'd1;
      end
      if (bus.mem_pop) begin
        if (bus.sel) lo <= lo + 6'd1;
        else         hi <= hi - 6'd1;
      end
    end
  end

  always_comb begin
    bus.mem_empty = (hi == lo);
    bus.mem_full  = ((hi - lo) == 6'd16);
    bus.mem_dout  = '0;
    if (hi != lo) bus.mem_dout = bus.sel ? m[lo] : m[hi - 6'd1];
  end

  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_y = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_y = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_y = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_y = bus.alu_a | bus.alu_b;
      default: bus.alu_y = bus.alu_a ^ bus.alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every mem_push must match the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("push_pop_exclusive", {31'b0, bus.mem_push & bus.mem_pop}, 32'd0);
        if (bus.mem_push) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_push: mem_din %0h with nothing expected", bus.mem_din);
          end else begin
            chk("push_data", bus.mem_din, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cmd(input bit ex, input bit po, input bit pu, input logic [15:0] sw, input logic [3:0] op);
    @(posedge clk); #1;
    bus.cmd_exec = ex; bus.cmd_pop = po; bus.cmd_push = pu;
    bus.switches = sw; bus.cmd_op = op;
    @(posedge clk); #1;
    bus.cmd_exec = 1'b0; bus.cmd_pop = 1'b0; bus.cmd_push = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_within_budget", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic push_sw(input logic [15:0] sw);
    exp_q.push_back({16'b0, sw});
    cmd(1'b0, 1'b0, 1'b1, sw, 4'd0);
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},    {27'b0, bus.count}, 32'd0);
    chk({tag, "_busy"},     {31'b0, bus.busy}, 32'd0);
    chk({tag, "_err"},      {31'b0, bus.err}, 32'd0);
    chk({tag, "_mem_push"}, {31'b0, bus.mem_push}, 32'd0);
    chk({tag, "_mem_pop"},  {31'b0, bus.mem_pop}, 32'd0);
    chk({tag, "_mem_din"},  bus.mem_din, 32'd0);
    chk({tag, "_alu_a"},    bus.alu_a, 32'd0);
    chk({tag, "_alu_b"},    bus.alu_b, 32'd0);
    chk({tag, "_alu_op"},   {28'b0, bus.alu_op}, 32'd0);
  endtask

  initial begin
    bus.sel = 1'b0; bus.cmd_push = 1'b0; bus.cmd_pop = 1'b0; bus.cmd_exec = 1'b0;
    bus.cmd_op = '0; bus.switches = '0;

    // Reset state, then two pushes
    @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b0;
    push_sw(16'd5);
    push_sw(16'd3);
    chk("t1_count", {27'b0, bus.count}, 32'd2);
    chk("t1_err", {31'b0, bus.err}, 32'd0);

    // Stack ADD on [5,3]: cycle-by-cycle strobes
    exp_q.push_back(32'd8);
    cmd(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    chk("t2_c1_pop", {31'b0, bus.mem_pop}, 32'd1);
    chk("t2_c1_busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    chk("t2_c2_pop", {31'b0, bus.mem_pop}, 32'd1);
    @(posedge clk); #1;
    chk("t2_c3_pop", {31'b0, bus.mem_pop}, 32'd0);
    chk("t2_c3_push", {31'b0, bus.mem_push}, 32'd0);
    chk("t2_c3_busy", {31'b0, bus.busy}, 32'd1);
    chk("t2_c3_count", {27'b0, bus.count}, 32'd0);
    chk("t2_alu_a", bus.alu_a, 32'd5);
    chk("t2_alu_b", bus.alu_b, 32'd3);
    @(posedge clk); #1;
    chk("t2_c4_push", {31'b0, bus.mem_push}, 32'd1);
    @(posedge clk); #1;
    chk("t2_c5_busy", {31'b0, bus.busy}, 32'd0);
    chk("t2_count", {27'b0, bus.count}, 32'd1);

    // Exec with one entry is illegal; a following legal push clears err
    cmd(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    chk("t4_err", {31'b0, bus.err}, 32'd1);
    chk("t4_no_pop", {31'b0, bus.mem_pop}, 32'd0);
    chk("t4_not_busy", {31'b0, bus.busy}, 32'd0);
    chk("t4_count", {27'b0, bus.count}, 32'd1);
    push_sw(16'd7);
    chk("t4_err_cleared", {31'b0, bus.err}, 32'd0);
    chk("t4_count2", {27'b0, bus.count}, 32'd2);

    // Queue SUB on [9,4]; cmd_op changes mid-operation are ignored
    do_reset();
    bus.sel = 1'b1;
    push_sw(16'd9);
    push_sw(16'd4);
    exp_q.push_back(32'd5);
    cmd(1'b1, 1'b0, 1'b0, 16'd0, 4'd1);
    bus.cmd_op = 4'd3;
    wait_idle();
    bus.cmd_op = 4'd0;
    chk("t3_alu_a", bus.alu_a, 32'd9);
    chk("t3_alu_b", bus.alu_b, 32'd4);
    chk("t3_alu_op", {28'b0, bus.alu_op}, 32'd1);
    chk("t3_count", {27'b0, bus.count}, 32'd1);

    // Underflow and overflow
    do_reset();
    bus.sel = 1'b0;
    cmd(1'b0, 1'b1, 1'b0, 16'd0, 4'd0);
    chk("t5_pop_empty_err", {31'b0, bus.err}, 32'd1);
    chk("t5_pop_empty_nopop", {31'b0, bus.mem_pop}, 32'd0);
    chk("t5_pop_empty_count", {27'b0, bus.count}, 32'd0);
    for (int i = 1; i <= 16; i++) push_sw(16'(i));
    chk("t5_full_count", {27'b0, bus.count}, 32'd16);
    chk("t5_full_err", {31'b0, bus.err}, 32'd0);
    cmd(1'b0, 1'b0, 1'b1, 16'd99, 4'd0);
    chk("t5_over_err", {31'b0, bus.err}, 32'd1);
    chk("t5_over_nopush", {31'b0, bus.mem_push}, 32'd0);
    chk("t5_over_count", {27'b0, bus.count}, 32'd16);

    // Simultaneous exec+pop+push picks exec; pulses while busy are dropped
    exp_q.push_back(32'd31);
    cmd(1'b1, 1'b1, 1'b1, 16'd77, 4'd0);
    chk("t6_exec_pop1", {31'b0, bus.mem_pop}, 32'd1);
    chk("t6_exec_busy", {31'b0, bus.busy}, 32'd1);
    bus.cmd_push = 1'b1; bus.cmd_pop = 1'b1;
    @(posedge clk); #1;
    bus.cmd_push = 1'b0; bus.cmd_pop = 1'b0;
    wait_idle();
    chk("t6_count", {27'b0, bus.count}, 32'd15);
    chk("t6_err", {31'b0, bus.err}, 32'd0);
    chk("t6_alu_a", bus.alu_a, 32'd15);
    chk("t6_alu_b", bus.alu_b, 32'd16);

    // Asynchronous reset while in POP2
    cmd(1'b1, 1'b0, 1'b0, 16'd0, 4'd2);
    @(posedge clk); #1;
    chk("t6_in_pop2", {31'b0, bus.mem_pop}, 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    push_sw(16'd42);
    chk("post_rst_count", {27'b0, bus.count}, 32'd1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
